// File: rtl/spi_slave_sync.sv
// Mode-0, MSB-first SPI responder. SCLK/CS_N/MOSI are resynchronised into clk and all
// edge detection runs on the synchronised copies; local side uses valid/ready TX and RX.
module spi_slave_sync #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  underrun,
    output logic                  overrun,
    output logic [1:0]            dbg_state_o
);
    // Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
    // valid holds its data stable until that edge, ready may change freely.

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] WORD_END = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_prev_q, cs_prev_q, armed_q;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-2:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]  hold_q, hold_d, rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0]  load_word, rx_word;
    logic                   full_q, full_d, miso_q, miso_d, rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d, overrun_q, overrun_d;
    logic                   sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic                   tx_wr, load;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign tx_wr     = tx_valid & ~full_q;
    assign rx_word   = {rx_sh_q, mosi_s};

    // A frame may only start once cs_n has been seen high with a fully refreshed synchroniser,
    // so a reset that lands mid-frame does not start decoding in the middle of a word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        underrun_d = 1'b0;
        overrun_d  = 1'b0;
        load       = 1'b0;
        load_word  = full_q ? hold_q : '0;

        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) state_d = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                underrun_d = ~full_q;
                miso_d     = load_word[DATA_WIDTH-1];
                tx_sh_d    = load_word[DATA_WIDTH-2:0];
                cnt_d      = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_sh_d = rx_word[DATA_WIDTH-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        overrun_d  = rx_valid_q & ~rx_ready;
                    end
                end else if (sclk_fall) begin
                    if (cnt_q == WORD_END) begin
                        state_d = LOAD;
                    end else begin
                        miso_d  = tx_sh_q[DATA_WIDTH-2];
                        tx_sh_d = {tx_sh_q[DATA_WIDTH-3:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end
    end

    // A load in the same cycle as a write takes the old (empty) contents; the new word stays.
    assign full_d = (full_q & ~load) | tx_wr;
    assign hold_d = tx_wr ? tx_data : hold_q;

    assign miso        = miso_q;
    assign busy        = ~cs_s;
    assign miso_oe     = ~cs_s;
    assign tx_ready    = ~full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign underrun    = underrun_q;
    assign overrun     = overrun_q;
    assign dbg_state_o = state_q;
endmodule
